// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: ARGN stb/rdy requesters share one registered {index, data} stream.
// Optional stalled-burst release is enabled by defining BURST_ARBITER_TIMEOUT_EN.
module burst_arbiter #(
   parameter int ARGW = 16,
   parameter int ARGN = 2,
   parameter int TMO  = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ARGN-1:0]              arg_stb,
   input  logic [ARGN-1:0]              arg_lst,
   input  logic [ARGN*ARGW-1:0]         arg_dat,
   output logic [ARGN-1:0]              arg_rdy,
   output logic                         res_stb,
   output logic                         res_lst,
   output logic [$clog2(ARGN)+ARGW-1:0] res_dat,
   input  logic                         res_rdy,
   output logic                         err
);

   localparam int IW = $clog2(ARGN);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        own_q, own_d;
   logic                 res_stb_q, res_stb_d;
   logic                 res_lst_q, res_lst_d;
   logic [IW+ARGW-1:0]   res_dat_q, res_dat_d;
   logic                 err_d;

   logic [IW-1:0]        srch_idx_s;
   logic                 srch_hit_s;
   logic [IW-1:0]        gnt_s;
   logic                 gnt_vld_s;
   logic                 gnt_lst_s;
   logic [ARGW-1:0]      gnt_dat_s;
   logic                 can_load_s;
   logic                 acc_s;

   if (ARGN < 2 || TMO < 1) begin : g_param_chk
      $error("burst_arbiter: ARGN must be >= 2 and TMO >= 1");
   end

   // base and off are both below ARGN, so one conditional subtract wraps correctly
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input logic [31:0] off);
      logic [31:0] sum;
      sum = 32'(base) + off;
      if (sum >= 32'(ARGN)) begin
         sum = sum - 32'(ARGN);
      end else begin
         sum = sum;
      end
      return IW'(sum);
   endfunction

   // Round-robin search: scan from the highest offset down so the nearest strobe wins
   always_comb begin
      srch_idx_s = ptr_q;
      srch_hit_s = 1'b0;
      for (int i = ARGN - 1; i >= 0; i--) begin
         if (arg_stb[wrap_inc(ptr_q, 32'(i))]) begin
            srch_hit_s = 1'b1;
            srch_idx_s = wrap_inc(ptr_q, 32'(i));
         end else begin
            srch_hit_s = srch_hit_s;
         end
      end
   end

   // Grantee selection, handshake qualification and the selected beat's payload
   always_comb begin
      gnt_s     = srch_idx_s;
      gnt_vld_s = srch_hit_s;
      gnt_lst_s = 1'b0;
      gnt_dat_s = '0;
      if (state_q == ST_LOCK) begin
         gnt_s     = own_q;
         gnt_vld_s = arg_stb[own_q];
      end else begin
         gnt_s     = srch_idx_s;
         gnt_vld_s = srch_hit_s;
      end
      for (int n = 0; n < ARGN; n++) begin
         if (gnt_s == IW'(n)) begin
            gnt_lst_s = arg_lst[n];
            gnt_dat_s = arg_dat[n*ARGW +: ARGW];
         end else begin
            gnt_lst_s = gnt_lst_s;
         end
      end
      can_load_s = ~res_stb_q | res_rdy;
      acc_s      = gnt_vld_s & can_load_s & rst;
      if (acc_s) begin
         arg_rdy = ARGN'(1) << gnt_s;
      end else begin
         arg_rdy = '0;
      end
   end

`ifdef BURST_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q;
`endif

   // Next-state: burst lock/unlock, pointer advance, output register load/clear
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      res_stb_d = res_stb_q;
      res_lst_d = res_lst_q;
      res_dat_d = res_dat_q;
      err_d     = 1'b0;
`ifdef BURST_ARBITER_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      if (acc_s) begin
         res_stb_d = 1'b1;
         res_lst_d = gnt_lst_s;
         res_dat_d = {gnt_s, gnt_dat_s};
         if (gnt_lst_s) begin
            state_d = ST_IDLE;
            ptr_d   = wrap_inc(gnt_s, 32'd1);
         end else begin
            state_d = ST_LOCK;
            own_d   = gnt_s;
         end
      end else if (res_rdy) begin
         res_stb_d = 1'b0;
      end else begin
         res_stb_d = res_stb_q;
      end
`ifdef BURST_ARBITER_TIMEOUT_EN
      // Only owner silence counts; a stalled-by-backpressure owner keeps its lock
      if ((state_q == ST_LOCK) && !acc_s && !arg_stb[own_q]) begin
         if (cnt_q == CW'(TMO - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = wrap_inc(own_q, 32'd1);
            cnt_d   = '0;
            err_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (acc_s || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q;
      end
`endif
   end

   // Arbiter state and output register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         own_q     <= '0;
         res_stb_q <= 1'b0;
         res_lst_q <= 1'b0;
         res_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         res_stb_q <= res_stb_d;
         res_lst_q <= res_lst_d;
         res_dat_q <= res_dat_d;
      end
   end

`ifdef BURST_ARBITER_TIMEOUT_EN
   // Stall counter and release pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_s;
   assign unused_s = err_d;
   assign err      = 1'b0;
`endif

   assign res_stb = res_stb_q;
   assign res_lst = res_lst_q;
   assign res_dat = res_dat_q;

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed bench for burst_arbiter (ARGN=3, TMO=8) with a per-cycle reference model.
`timescale 1ns/1ps
module tb_burst_arbiter;
   localparam int ARGW = 16;
   localparam int ARGN = 3;
   localparam int TMO  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  arg_stb;
   logic [2:0]  arg_lst;
   logic [47:0] arg_dat;
   logic [2:0]  arg_rdy;
   logic        res_stb;
   logic        res_lst;
   logic [17:0] res_dat;
   logic        res_rdy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   burst_arbiter #(.ARGW(ARGW), .ARGN(ARGN), .TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .arg_stb(arg_stb), .arg_lst(arg_lst), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
      .res_stb(res_stb), .res_lst(res_lst), .res_dat(res_dat), .res_rdy(res_rdy),
      .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: lock owner, rotating pointer, one pending output beat
   bit          m_lock = 1'b0;
   int          m_ptr  = 0;
   int          m_own  = 0;
   int          m_cnt  = 0;
   bit          m_stb  = 1'b0;
   bit          m_lst  = 1'b0;
   bit          m_err  = 1'b0;
   logic [17:0] m_dat  = 18'h00000;

   always @(negedge clk) begin : model_cmp
      int         g;
      logic [2:0] exp_rdy;
      chk("m_res_stb", res_stb, m_stb);
      if (m_stb) begin
         chk("m_res_lst", res_lst, m_lst);
         chk("m_res_dat", res_dat, m_dat);
      end
      chk("m_err", err, m_err);
      g = -1;
      if (rst && (!m_stb || res_rdy)) begin
         if (m_lock) begin
            if (arg_stb[m_own]) g = m_own;
         end else begin
            for (int k = 0; k < ARGN; k++) begin
               if (g < 0 && arg_stb[(m_ptr + k) % ARGN]) g = (m_ptr + k) % ARGN;
            end
         end
      end
      exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
      chk("m_arg_rdy", arg_rdy, exp_rdy);
      if (!rst) begin
         m_lock = 1'b0; m_ptr = 0; m_own = 0; m_cnt = 0;
         m_stb = 1'b0; m_lst = 1'b0; m_err = 1'b0; m_dat = 18'h00000;
      end else begin
         m_err = 1'b0;
         if (g >= 0) begin
            m_stb = 1'b1;
            m_lst = arg_lst[g];
            m_dat = {2'(g), arg_dat[g*16 +: 16]};
            m_cnt = 0;
            if (arg_lst[g]) begin
               m_lock = 1'b0;
               m_ptr  = (g + 1) % ARGN;
            end else begin
               m_lock = 1'b1;
               m_own  = g;
            end
         end else if (res_rdy) begin
            m_stb = 1'b0;
         end
`ifdef BURST_ARBITER_TIMEOUT_EN
         if (m_lock && g < 0 && !arg_stb[m_own]) begin
            m_cnt++;
            if (m_cnt == TMO) begin
               m_lock = 1'b0;
               m_ptr  = (m_own + 1) % ARGN;
               m_cnt  = 0;
               m_err  = 1'b1;
            end
         end
`endif
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   logic [17:0] rr_exp [3];
   int err_at, rdy1_at, res1_at, err_cnt;

   initial begin
      rr_exp[0] = 18'h0A000;
      rr_exp[1] = 18'h1B001;
      rr_exp[2] = 18'h2C002;

      // Reset with every requester strobing
      rst = 1'b0; res_rdy = 1'b1;
      arg_stb = 3'b111; arg_lst = 3'b111;
      arg_dat = {16'hC002, 16'hB001, 16'hA000};
      repeat (3) begin
         mid();
         chk("rst_arg_rdy", arg_rdy, 3'b000);
         chk("rst_res_stb", res_stb, 1'b0);
      end
      cyc();
      rst = 1'b1;
      mid();
      chk("first_grant", arg_rdy, 3'b001);
      chk("first_res_stb", res_stb, 1'b0);
      mid();
      chk("first_res_dat", res_dat, 18'h0A000);
      chk("first_res_stb1", res_stb, 1'b1);

      // Round-robin wrap, one beat per cycle
      for (int k = 1; k <= 5; k++) begin
         mid();
         chk("rr_stb", res_stb, 1'b1);
         chk("rr_dat", res_dat, rr_exp[k % 3]);
      end
      cyc();
      arg_stb = 3'b000;
      cyc();

      // Burst lock on ch1 while ch0 and ch2 strobe
      arg_stb = 3'b111; arg_lst = 3'b101; arg_dat[31:16] = 16'h1111;
      mid();
      chk("lock_grant", arg_rdy, 3'b010);
      cyc();
      arg_dat[31:16] = 16'h2222;
      mid();
      chk("lock_b1_dat", res_dat, 18'h11111);
      chk("lock_b1_lst", res_lst, 1'b0);
      chk("lock_hold_rdy", arg_rdy, 3'b010);
      cyc();
      arg_dat[31:16] = 16'h3333; arg_lst = 3'b111;
      mid();
      chk("lock_b2_dat", res_dat, 18'h12222);
      chk("lock_b2_lst", res_lst, 1'b0);
      mid();
      chk("lock_b3_dat", res_dat, 18'h13333);
      chk("lock_b3_lst", res_lst, 1'b1);
      chk("after_lock_ch2", arg_rdy, 3'b100);
      mid();
      chk("after_lock_ch2_dat", res_dat, 18'h2C002);
      chk("after_lock_ch0", arg_rdy, 3'b001);

      // Backpressure
      cyc();
      arg_stb = 3'b010; arg_dat[31:16] = 16'hABCD;
      mid();
      chk("bp_pre_dat", res_dat, 18'h0A000);
      cyc();
      res_rdy = 1'b0; arg_stb = 3'b011; arg_dat[31:16] = 16'h1234;
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("bp_dat", res_dat, 18'h1ABCD);
         chk("bp_stb", res_stb, 1'b1);
         chk("bp_rdy", arg_rdy, 3'b000);
      end
      cyc();
      res_rdy = 1'b1;
      mid();
      chk("bp_release_rdy", arg_rdy, 3'b001);
      chk("bp_release_hold", res_dat, 18'h1ABCD);
      mid();
      chk("bp_release_dat", res_dat, 18'h0A000);

      // Stall: ch0 opens a burst and goes silent, ch1 waits
      cyc();
      arg_stb = 3'b001; arg_lst = 3'b000; arg_dat[15:0] = 16'h5555;
      mid();
      chk("stall_grant", arg_rdy, 3'b001);
      cyc();
      arg_stb = 3'b010; arg_lst = 3'b010; arg_dat[31:16] = 16'hBEEF;
      err_at = -1; rdy1_at = -1; res1_at = -1; err_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         mid();
         if (err === 1'b1) begin
            err_cnt++;
            if (err_at < 0) err_at = c;
         end
         if (arg_rdy[1] === 1'b1 && rdy1_at < 0) rdy1_at = c;
         if (res_stb === 1'b1 && res_dat === 18'h1BEEF && res1_at < 0) res1_at = c;
      end
`ifdef BURST_ARBITER_TIMEOUT_EN
      chk("tmo_err_at", err_at, 32'd8);
      chk("tmo_err_cnt", err_cnt, 32'd1);
      chk("tmo_rdy1_at", rdy1_at, 32'd8);
      chk("tmo_res1_at", res1_at, 32'd9);
`else
      chk("notmo_rdy1", rdy1_at, 32'hFFFFFFFF);
      chk("notmo_res1", res1_at, 32'hFFFFFFFF);
      chk("notmo_err", err_cnt, 32'd0);
`endif

      // Reset in the middle of a ch0 burst
      cyc();
      rst = 1'b0; arg_stb = 3'b000;
      cyc();
      rst = 1'b1; arg_stb = 3'b001; arg_lst = 3'b000; arg_dat[15:0] = 16'h6000;
      mid();
      chk("mr_b1_rdy", arg_rdy, 3'b001);
      cyc();
      arg_dat[15:0] = 16'h6001;
      mid();
      chk("mr_b2_rdy", arg_rdy, 3'b001);
      chk("mr_b1_dat", res_dat, 18'h06000);
      cyc();
      arg_stb = 3'b010; arg_lst = 3'b010; arg_dat[31:16] = 16'h7777; rst = 1'b0;
      mid();
      chk("mr_rst_rdy", arg_rdy, 3'b000);
      cyc();
      rst = 1'b1;
      mid();
      chk("mr_res_stb", res_stb, 1'b0);
      chk("mr_regrant", arg_rdy, 3'b010);
      mid();
      chk("mr_ch1_dat", res_dat, 18'h17777);
      cyc();
      arg_stb = 3'b000;
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/burst_arbiter.md
Name: burst_arbiter

Overview:
- Round-robin arbiter that shares one tagged result stream between ARGN stb/rdy requesters.
- Requesters send multi-beat bursts delimited by a last flag. Once a requester is granted, it holds the channel until its last beat is accepted, so bursts are never interleaved.
- Sits in front of downstream consumers of tagged argument streams. Output format is {index, data}.

Parameters:
- ARGW, 16, data width per requester.
- ARGN, 2, number of requesters; must be >= 2; need not be a power of two.
- TMO, 256, idle cycles before a stalled burst is force-released. Used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- arg_stb  input  ARGN  per-requester strobe (valid).
- arg_lst  input  ARGN  per-requester last-beat flag; qualified by arg_stb.
- arg_dat  input  ARGN*ARGW  packed data; requester n occupies bits [n*ARGW +: ARGW].
- arg_rdy  output  ARGN  per-requester ready; one-hot or zero.
- res_stb  output  1  result valid (registered).
- res_lst  output  1  result last-beat flag (registered).
- res_dat  output  $clog2(ARGN)+ARGW  {requester index, data} (registered).
- res_rdy  input  1  downstream ready.
- err  output  1  one-cycle pulse on forced burst release; tied 0 without the optional feature.

Behaviour:
- Handshakes:
  - Beat accepted from n when arg_stb[n] & arg_rdy[n].
  - res_ack = res_stb & res_rdy.
  - Output register can load when ~res_stb | res_rdy.
- arg_rdy: one-hot of the current grantee when the output register can load and rst=1, otherwise 0. It is never asserted for a requester whose arg_stb=0.
- State IDLE:
  - Grantee is the first n with arg_stb[n]=1, searching ptr, ptr+1, ... modulo ARGN.
  - If no strobes are asserted: no grant, arg_rdy=0.
  - Accepted beat with lst=1: stay IDLE, ptr <= (n+1) mod ARGN.
  - Accepted beat with lst=0: go to LOCK, own <= n.
- State LOCK:
  - Grantee is own only; all other requesters see arg_rdy=0 regardless of their strobes.
  - Accepted beat with lst=1: go to IDLE, ptr <= (own+1) mod ARGN.
  - If the owner deasserts arg_stb mid-burst, LOCK is held.
- Wrap-around: ptr and the search index wrap modulo ARGN, e.g. ARGN=3 wraps 2->0. Index values >= ARGN never appear.
- Output register load on accept:
  - res_stb <= 1
  - res_lst <= arg_lst[n]
  - res_dat <= {n, arg_dat[n*ARGW +: ARGW]}
- Output register clear: on res_ack without a new accept, res_stb <= 0.
- Latency and throughput: latency is 1 cycle from accept to res_stb. With res_rdy held at 1, throughput is one beat per cycle, including back-to-back beats from different requesters.
- Backpressure: while res_stb=1 and res_rdy=0, res_dat and res_lst hold stable and arg_rdy=0.
- Simultaneous events: res_ack and a new accept in the same cycle load the new beat and keep res_stb=1.
- Reset (rst=0 at a clock edge):
  - state IDLE, ptr=0, own=0
  - res_stb=0, res_lst=0, res_dat=0, err=0, timeout counter 0
  - arg_rdy=0 combinationally while rst=0
  - Reset mid-burst drops the lock and any held output beat.

Optional Feature:
- Macro: BURST_ARBITER_TIMEOUT_EN.
- With the macro: in LOCK, a counter increments on each cycle with arg_stb[own]=0 and clears on any owner beat. When it reaches TMO:
  - go to IDLE, ptr <= (own+1) mod ARGN, counter cleared
  - err pulses 1 for one cycle
  - the output register is unaffected
- Without the macro: no counter, err constantly 0, LOCK is held indefinitely.

Test Plan:
- Reset: ARGN=3, all arg_stb=1, lst=1, rst=0 for 3 cycles -> arg_rdy=0, res_stb=0. First cycle after release: arg_rdy=3'b001; next cycle res_dat={2'd0, d0}.
- Round-robin wrap: ARGN=3, all requesters single-beat continuously, res_rdy=1 -> res_dat tags 0,1,2,0,1,2 on consecutive cycles, res_stb never drops.
- Burst lock: ch1 sends 3 beats (lst on the 3rd) while ch0 and ch2 strobe -> three consecutive tag-1 results, res_lst=1 only on the third; the next grant is ch2, then ch0.
- Backpressure: res_stb=1 with res_dat=0x1_ABCD, res_rdy=0 for 5 cycles -> res_dat constant, arg_rdy=0. res_rdy=1 -> the next beat loads in the same cycle.
- Stall and timeout, TMO=8:
  - ch0 sends a lst=0 beat then drops stb, ch1 strobes.
  - With the macro: err pulses exactly 8 cycles later, and ch1 is accepted on the following cycle.
  - Without the macro: ch1 is never granted within 50 cycles.
- Reset mid-burst: ch0 locked after 2 beats, rst=0 for 1 cycle -> res_stb=0, state IDLE. ch1 is granted immediately after if ch0 is idle.
